maxpool_relu_nch: RTL

- Parametrised successor of the fixed 3-channel, 12-bit, 8x8 pooling stage.
- Performs 2x2 stride-2 max pooling plus ReLU on a raster-order stream of CH-channel signed convolution outputs.
- Sits between a conv stage and the next conv or FC stage.
- Adds generic width, depth and channel count, a runtime ReLU bypass, and frame/row framing outputs.

---
 rtl/maxpool_pkg.sv | 32 +++
 rtl/pool_lane.sv | 39 +++
 rtl/maxpool_relu_nch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/maxpool_pkg.sv
// Shared constants and per-sample helpers for the N-channel max-pool + ReLU stage.
// Optional feature macro: MAXPOOL_LEAKY_RELU_EN (leaky ReLU, slope 1/8, instead of clamp to 0).
package maxpool_pkg;

  localparam int DATA_W_DEF  = 12;
  localparam int CH_DEF      = 3;
  localparam int LEAKY_SHIFT = 3;

  // Helpers work on a wide signed type; callers sign-extend in and size-cast out.
  localparam int WIDE_W = 32;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Signed max, strict greater-than: on a tie the first operand (the buffered value) wins.
  function automatic wide_t smax(input wide_t a, input wide_t b);
    return (b > a) ? b : a;
  endfunction

  // ReLU with runtime bypass; en=0 passes the value unchanged.
  function automatic wide_t relu(input wide_t x, input logic en);
    wide_t r;
    r = x;
    if (en && (x < 0)) begin
`ifdef MAXPOOL_LEAKY_RELU_EN
      r = x >>> LEAKY_SHIFT;
`else
      r = '0;
`endif
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel of the pooling datapath: line-buffer entry update, window max and ReLU.
// Leaky ReLU variant selected by MAXPOOL_LEAKY_RELU_EN (see maxpool_pkg).
module pool_lane
  import maxpool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              upd,
  input  logic              load,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] din,
  input  logic              relu_en,
  output logic [DATA_W-1:0] result
);

  logic signed [DATA_W-1:0] line_buf [DEPTH];
  logic signed [DATA_W-1:0] held;
  logic signed [DATA_W-1:0] samp;
  logic signed [DATA_W-1:0] win_max;

  // Running max of the buffered partial window and the incoming sample, then ReLU.
  always_comb begin
    held    = line_buf[idx];
    samp    = $signed(din);
    win_max = DATA_W'(smax(wide_t'(held), wide_t'(samp)));
    result  = DATA_W'(relu(wide_t'(win_max), relu_en));
  end

  // Buffer contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    if (upd) begin
      line_buf[idx] <= load ? samp : win_max;
    end
  end

endmodule

// File: rtl/maxpool_relu_nch.sv
// 2x2 stride-2 max pooling + ReLU over a raster-order stream of CH signed channels.
// Owns the column/row counters, the framing flags and the output registers.
// Optional feature macro: MAXPOOL_LEAKY_RELU_EN (leaky ReLU, handled in maxpool_pkg::relu).
module maxpool_relu_nch
  import maxpool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CH     = CH_DEF,
  parameter int IN_W   = 8,
  parameter int IN_H   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [CH*DATA_W-1:0] data_in,
  input  logic                 relu_en,
  output logic [CH*DATA_W-1:0] data_out,
  output logic                 valid_out,
  output logic                 row_last,
  output logic                 frame_last
);

  localparam int COL_W  = $clog2(IN_W / 2) + 1;
  localparam int ROW_W  = $clog2(IN_H / 2) + 1;
  localparam int HALF_W = IN_W / 2;
  localparam int HALF_H = IN_H / 2;
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic [COL_W-1:0] PcolLast = COL_W'(HALF_W - 1);
  localparam logic [ROW_W-1:0] ProwLast = ROW_W'(HALF_H - 1);

  if (((IN_W % 2) != 0) || (IN_W < 2)) begin : g_bad_in_w
    $error("maxpool_relu_nch: IN_W must be even and >= 2");
  end
  if (((IN_H % 2) != 0) || (IN_H < 2)) begin : g_bad_in_h
    $error("maxpool_relu_nch: IN_H must be even and >= 2");
  end
  if ((DATA_W < 1) || (DATA_W > WIDE_W)) begin : g_bad_data_w
    $error("maxpool_relu_nch: DATA_W must be in 1..32");
  end

  logic             pair_q, pair_d;     // 1 = current input column is odd
  logic             rphase_q, rphase_d; // 1 = current input row is odd
  logic [COL_W-1:0] pcol_q, pcol_d;
  logic [ROW_W-1:0] prow_q, prow_d;

  logic                 complete;
  logic                 lane_upd;
  logic                 lane_load;
  logic [CH*DATA_W-1:0] pooled;

  logic [CH*DATA_W-1:0] data_out_q;
  logic                 valid_out_q;
  logic                 row_last_q;
  logic                 frame_last_q;

  // The 4th window sample (odd row, odd column) produces a result instead of a buffer write.
  assign complete  = valid_in & rphase_q & pair_q;
  assign lane_upd  = valid_in & ~(rphase_q & pair_q);
  assign lane_load = ~rphase_q & ~pair_q;

  // Position counters advance only on accepted pixels; everything holds during gaps.
  always_comb begin
    pair_d   = pair_q;
    pcol_d   = pcol_q;
    rphase_d = rphase_q;
    prow_d   = prow_q;
    if (valid_in) begin
      pair_d = ~pair_q;
      if (pair_q) begin
        if (pcol_q == PcolLast) begin
          pcol_d   = '0;
          rphase_d = ~rphase_q;
          if (rphase_q) begin
            prow_d = (prow_q == ProwLast) ? '0 : prow_q + 1'b1;
          end
        end else begin
          pcol_d = pcol_q + 1'b1;
        end
      end
    end
  end

  // Counter state register; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q   <= 1'b0;
      pcol_q   <= '0;
      rphase_q <= 1'b0;
      prow_q   <= '0;
    end else begin
      pair_q   <= pair_d;
      pcol_q   <= pcol_d;
      rphase_q <= rphase_d;
      prow_q   <= prow_d;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    pool_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (HALF_W),
      .IDX_W  (IDX_W)
    ) u_lane (
      .clk     (clk),
      .upd     (lane_upd),
      .load    (lane_load),
      .idx     (pcol_q[IDX_W-1:0]),
      .din     (data_in[c*DATA_W +: DATA_W]),
      .relu_en (relu_en),
      .result  (pooled[c*DATA_W +: DATA_W])
    );
  end

  // Output registers: one-cycle valid pulse with framing flags, data held between outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      row_last_q   <= 1'b0;
      frame_last_q <= 1'b0;
    end else begin
      valid_out_q  <= complete;
      row_last_q   <= complete && (pcol_q == PcolLast);
      frame_last_q <= complete && (pcol_q == PcolLast) && (prow_q == ProwLast);
      if (complete) begin
        data_out_q <= pooled;
      end
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign row_last   = row_last_q;
  assign frame_last = frame_last_q;

endmodule
